// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch front end: issues word reads to the memory
//            controller, tracks the PC and queues fetched words for decode.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    input  logic        mem_busy_in,
    input  logic        inst_done_in,
    input  logic [31:0] inst_in,
    output logic        if_req_out,
    output logic [31:0] inst_addr_out,
    output logic        if_valid_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_inst_out
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_req  = 2'd1;
    localparam logic [1:0]  c_st_drop = 2'd2;
    localparam logic [31:0] c_pc_step = 32'(PC_STEP);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_req;
    logic        w_req_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic [31:0] r_q0_pc;
    logic [31:0] r_q0_inst;
    logic [31:0] r_q1_pc;
    logic [31:0] r_q1_inst;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc_in & ~32'h0000_0003;
    assign w_pop         = (r_count != 2'd0) && !stall_in && !redirect_in;

    // A started transfer always runs to inst_done_in; redirects only decide
    // whether the returned word is kept.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!redirect_in && !mem_busy_in && (r_count != 2'd2)) begin
                    w_state_nxt = c_st_req;
                    w_req_nxt   = 1'b1;
                    w_issue     = 1'b1;
                end
            end
            c_st_req: begin
                if (inst_done_in) begin
                    w_state_nxt = c_st_idle;
                    w_req_nxt   = 1'b0;
                    w_push      = !redirect_in;
                end else if (redirect_in) begin
                    w_state_nxt = c_st_drop;
                end
            end
            c_st_drop: begin
                if (inst_done_in) begin
                    w_state_nxt = c_st_idle;
                    w_req_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= c_st_idle;
            r_req   <= 1'b0;
            r_addr  <= 32'h0;
            r_pc    <= RESET_PC;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            if (w_issue) begin
                r_addr <= r_pc;
            end
            if (redirect_in) begin
                r_pc <= w_redirect_pc;
            end else if (w_push) begin
                r_pc <= r_pc + c_pc_step;
            end
        end
    end

    // Shift-style queue: entry 0 is always the head seen by decode.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count   <= 2'd0;
            r_q0_pc   <= 32'h0;
            r_q0_inst <= 32'h0;
            r_q1_pc   <= 32'h0;
            r_q1_inst <= 32'h0;
        end else if (rdy_in) begin
            if (redirect_in) begin
                r_count <= 2'd0;
            end else begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_q0_pc   <= r_pc;
                            r_q0_inst <= inst_in;
                        end else begin
                            r_q1_pc   <= r_pc;
                            r_q1_inst <= inst_in;
                        end
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        r_q0_pc   <= r_q1_pc;
                        r_q0_inst <= r_q1_inst;
                        r_count   <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_q0_pc   <= r_pc;
                            r_q0_inst <= inst_in;
                        end else begin
                            r_q0_pc   <= r_q1_pc;
                            r_q0_inst <= r_q1_inst;
                            r_q1_pc   <= r_pc;
                            r_q1_inst <= inst_in;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign if_req_out    = r_req;
    assign inst_addr_out = r_addr;
    assign if_valid_out  = (r_count != 2'd0);
    assign if_pc_out     = r_q0_pc;
    assign if_inst_out   = r_q0_inst;

endmodule

`default_nettype wire
